// File: rtl/cci_wr_req_throttle.sv
// CCI-S TX channel 1 write-request issue stage: buffers user writes in a small FIFO and
// issues them when the channel has room and the outstanding-write credit limit allows.
module cci_wr_req_throttle #(
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 32,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usr_wr_valid,
  output logic              usr_wr_ready,
  input  logic [60:0]       usr_wr_hdr,
  input  logic [511:0]      usr_wr_data,
  input  logic              cci_tx_wr_almostfull,
  output logic              spl_tx_wr_valid,
  output logic [60:0]       spl_tx_wr_hdr,
  output logic [511:0]      spl_tx_data,
  input  logic              cci_rx_wr_valid0,
  input  logic              cci_rx_wr_valid1,
  output logic [CNT_W-1:0]  outstanding_cnt,
  output logic              idle,
  output logic              err_underflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [572:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             valid_q, valid_d;
  logic [60:0]      hdr_q, hdr_d;
  logic [511:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             push;
  logic             issue;
  logic [CNT_W+1:0] cnt_inc;
  logic [CNT_W+1:0] cnt_dec;

  assign usr_wr_ready = (count_q != (AW + 1)'(FIFO_DEPTH));
  assign push         = usr_wr_valid & usr_wr_ready;
  assign issue        = (count_q != {(AW + 1){1'b0}}) & ~cci_tx_wr_almostfull &
                        (cnt_q < CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    hdr_d    = hdr_q;
    data_d   = data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + {{(AW - 1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + {{(AW - 1){1'b0}}, 1'b1};
      valid_d  = 1'b1;
      {hdr_d, data_d} = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, issue})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Credits: a response with nothing outstanding clamps at zero and latches the error.
  always_comb begin
    cnt_inc = {2'b00, cnt_q} + {{(CNT_W + 1){1'b0}}, issue};
    cnt_dec = {{(CNT_W + 1){1'b0}}, cci_rx_wr_valid0} + {{(CNT_W + 1){1'b0}}, cci_rx_wr_valid1};
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (cnt_inc < cnt_dec) begin
      cnt_d = {CNT_W{1'b0}};
      err_d = 1'b1;
    end else begin
      cnt_d = CNT_W'(cnt_inc - cnt_dec);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {usr_wr_hdr, usr_wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
      valid_q  <= 1'b0;
      hdr_q    <= 61'd0;
      data_q   <= 512'd0;
      cnt_q    <= {CNT_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      hdr_q    <= hdr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign spl_tx_wr_valid = valid_q;
  assign spl_tx_wr_hdr   = hdr_q;
  assign spl_tx_data     = data_q;
  assign outstanding_cnt = cnt_q;
  assign err_underflow   = err_q;
  assign idle            = (count_q == {(AW + 1){1'b0}}) & (cnt_q == {CNT_W{1'b0}}) & ~valid_q;

endmodule

// File: tb/tb_cci_wr_req_throttle.sv
// Directed bench for cci_wr_req_throttle: a default instance and a MAX_OUTSTANDING=2 instance,
// each with a scoreboard queue of expected headers checked when spl_tx_wr_valid fires.
module tb_cci_wr_req_throttle;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance
  logic         usr_wr_valid, usr_wr_ready;
  logic [60:0]  usr_wr_hdr;
  logic [511:0] usr_wr_data;
  logic         af, rx0, rx1;
  logic         spl_tx_wr_valid;
  logic [60:0]  spl_tx_wr_hdr;
  logic [511:0] spl_tx_data;
  logic [5:0]   cnt;
  logic         idle, err;

  // MAX_OUTSTANDING=2 instance
  logic         d2_valid, d2_ready;
  logic [60:0]  d2_hdr;
  logic [511:0] d2_data;
  logic         d2_af, d2_rx0, d2_rx1;
  logic         d2_tx_valid;
  logic [60:0]  d2_tx_hdr;
  logic [511:0] d2_tx_data;
  logic [1:0]   d2_cnt;
  logic         d2_idle, d2_err;

  cci_wr_req_throttle u_dut (
    .clk(clk), .rst(rst),
    .usr_wr_valid(usr_wr_valid), .usr_wr_ready(usr_wr_ready),
    .usr_wr_hdr(usr_wr_hdr), .usr_wr_data(usr_wr_data),
    .cci_tx_wr_almostfull(af),
    .spl_tx_wr_valid(spl_tx_wr_valid), .spl_tx_wr_hdr(spl_tx_wr_hdr), .spl_tx_data(spl_tx_data),
    .cci_rx_wr_valid0(rx0), .cci_rx_wr_valid1(rx1),
    .outstanding_cnt(cnt), .idle(idle), .err_underflow(err)
  );

  cci_wr_req_throttle #(.FIFO_DEPTH(8), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .usr_wr_valid(d2_valid), .usr_wr_ready(d2_ready),
    .usr_wr_hdr(d2_hdr), .usr_wr_data(d2_data),
    .cci_tx_wr_almostfull(d2_af),
    .spl_tx_wr_valid(d2_tx_valid), .spl_tx_wr_hdr(d2_tx_hdr), .spl_tx_data(d2_tx_data),
    .cci_rx_wr_valid0(d2_rx0), .cci_rx_wr_valid1(d2_rx1),
    .outstanding_cnt(d2_cnt), .idle(d2_idle), .err_underflow(d2_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_iss1 = 0;
  int n_iss2 = 0;
  logic [60:0] q1[$];
  logic [60:0] q2[$];

  function automatic logic [511:0] mk_data(input logic [60:0] h);
    logic [511:0] d;
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = {h, 3'(i)} ^ 64'h5A5A_C3C3_0F0F_9669;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [60:0] h, output bit acc);
    usr_wr_valid = 1'b1;
    usr_wr_hdr   = h;
    usr_wr_data  = mk_data(h);
    acc = usr_wr_ready;
    if (acc) q1.push_back(h);
    tick();
    usr_wr_valid = 1'b0;
  endtask

  // Scoreboard check for the default instance.
  always @(negedge clk) begin
    if (spl_tx_wr_valid === 1'b1) begin
      logic [60:0] e;
      n_iss1++;
      if (q1.size() == 0) begin
        chk("dut1_issue_with_nothing_expected", spl_tx_wr_valid, 1'b0);
      end else begin
        e = q1.pop_front();
        chk("dut1_hdr", spl_tx_wr_hdr, e);
        chk("dut1_data", spl_tx_data, mk_data(e));
      end
    end
  end

  // Scoreboard check for the MAX_OUTSTANDING=2 instance.
  always @(negedge clk) begin
    if (d2_tx_valid === 1'b1) begin
      logic [60:0] e;
      n_iss2++;
      if (q2.size() == 0) begin
        chk("dut2_issue_with_nothing_expected", d2_tx_valid, 1'b0);
      end else begin
        e = q2.pop_front();
        chk("dut2_hdr", d2_tx_hdr, e);
        chk("dut2_data", d2_tx_data, mk_data(e));
      end
    end
  end

  initial begin
    bit acc;
    int iss_before;
    rst = 1'b1;
    usr_wr_valid = 1'b0; usr_wr_hdr = '0; usr_wr_data = '0;
    af = 1'b0; rx0 = 1'b0; rx1 = 1'b0;
    d2_valid = 1'b0; d2_hdr = '0; d2_data = '0;
    d2_af = 1'b0; d2_rx0 = 1'b0; d2_rx1 = 1'b0;
    tick();
    tick();
    chk("rst_valid", spl_tx_wr_valid, 1'b0);
    chk("rst_hdr", spl_tx_wr_hdr, 61'd0);
    chk("rst_data", spl_tx_data, 512'd0);
    chk("rst_cnt", cnt, 6'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", usr_wr_ready, 1'b1);
    chk("rst_idle", idle, 1'b1);
    rst = 1'b0;

    // Back-to-back 4 requests, 2-cycle latency, 4 consecutive issues.
    push1(61'd1, acc);
    chk("t1_valid_after_accept", spl_tx_wr_valid, 1'b0);
    push1(61'd2, acc);
    chk("t1_first_valid", spl_tx_wr_valid, 1'b1);
    chk("t1_first_hdr", spl_tx_wr_hdr, 61'd1);
    push1(61'd3, acc);
    chk("t1_valid2", spl_tx_wr_valid, 1'b1);
    push1(61'd4, acc);
    chk("t1_valid3", spl_tx_wr_valid, 1'b1);
    tick();
    chk("t1_valid4", spl_tx_wr_valid, 1'b1);
    chk("t1_hdr4", spl_tx_wr_hdr, 61'd4);
    tick();
    chk("t1_valid_end", spl_tx_wr_valid, 1'b0);
    chk("t1_cnt4", cnt, 6'd4);
    chk("t1_hdr_hold", spl_tx_wr_hdr, 61'd4);
    rx0 = 1'b1;
    repeat (4) tick();
    rx0 = 1'b0;
    chk("t1_cnt0", cnt, 6'd0);
    chk("t1_idle", idle, 1'b1);
    chk("t1_no_err", err, 1'b0);

    // MAX_OUTSTANDING=2: credit stall and single-credit release.
    for (int i = 0; i < 5; i++) begin
      d2_valid = 1'b1;
      d2_hdr   = 61'(100 + i);
      d2_data  = mk_data(d2_hdr);
      if (d2_ready) q2.push_back(d2_hdr);
      tick();
    end
    d2_valid = 1'b0;
    chk("t3_all_accepted", q2.size() + n_iss2, 5);
    repeat (4) tick();
    chk("t3_two_issues", n_iss2, 2);
    chk("t3_cnt2", d2_cnt, 2'd2);
    chk("t3_stalled", d2_tx_valid, 1'b0);
    d2_rx0 = 1'b1;
    tick();
    d2_rx0 = 1'b0;
    chk("t3_cnt1", d2_cnt, 2'd1);
    chk("t3_no_issue_yet", d2_tx_valid, 1'b0);
    tick();
    chk("t3_reissue", d2_tx_valid, 1'b1);
    chk("t3_cnt_back2", d2_cnt, 2'd2);
    repeat (4) tick();
    chk("t3_three_issues", n_iss2, 3);
    chk("t3_cnt_stays2", d2_cnt, 2'd2);

    // Almost-full hold, FIFO full, then release.
    af = 1'b1;
    for (int i = 0; i < 8; i++) push1(61'(10 + i), acc);
    chk("t2_ready_full", usr_wr_ready, 1'b0);
    push1(61'd18, acc);
    chk("t2_ninth_held", acc, 1'b0);
    chk("t2_no_valid", spl_tx_wr_valid, 1'b0);
    chk("t2_no_issue_cnt", cnt, 6'd0);
    af = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push1(61'd18, acc);
      if (acc) break;
    end
    chk("t2_ninth_accepted", acc, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (q1.size() == 0) break;
      tick();
    end
    chk("t2_drained", q1.size(), 0);
    tick();
    chk("t2_cnt9", cnt, 6'd9);
    rx1 = 1'b1;
    repeat (9) tick();
    rx1 = 1'b0;
    chk("t2_cnt0", cnt, 6'd0);
    chk("t2_idle", idle, 1'b1);

    // Dual response and underflow.
    for (int i = 0; i < 3; i++) push1(61'(30 + i), acc);
    repeat (4) tick();
    chk("t4_cnt3", cnt, 6'd3);
    rx0 = 1'b1; rx1 = 1'b1;
    tick();
    chk("t4_cnt1", cnt, 6'd1);
    chk("t4_no_err", err, 1'b0);
    tick();
    rx0 = 1'b0; rx1 = 1'b0;
    chk("t4_clamp0", cnt, 6'd0);
    chk("t4_err", err, 1'b1);
    repeat (3) tick();
    chk("t4_err_sticky", err, 1'b1);

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) push1(61'(40 + i), acc);
    repeat (4) tick();
    chk("t5_cnt3", cnt, 6'd3);
    af = 1'b1;
    for (int i = 0; i < 5; i++) push1(61'(50 + i), acc);
    chk("t5_buffered_idle_low", idle, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q1.delete();
    iss_before = n_iss1;
    chk("t5_valid", spl_tx_wr_valid, 1'b0);
    chk("t5_cnt", cnt, 6'd0);
    chk("t5_ready", usr_wr_ready, 1'b1);
    chk("t5_idle", idle, 1'b1);
    chk("t5_err_cleared", err, 1'b0);
    af = 1'b0;
    repeat (20) tick();
    chk("t5_no_stale_issue", n_iss1, iss_before);
    chk("t5_idle_after", idle, 1'b1);
    rx0 = 1'b1;
    tick();
    rx0 = 1'b0;
    chk("t5_stale_resp_err", err, 1'b1);
    chk("t5_stale_resp_cnt", cnt, 6'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cci_wr_req_throttle.md
Name: cci_wr_req_throttle

Overview:
- Write-request issue stage between user AFU logic inside fpga_arch and the CCI-S TX channel 1 write-request outputs (spl_tx_wr_*).
- Buffers user write requests (header plus 512-bit cache line) in a small FIFO.
- Issues them to CCI only when the channel is not almost full and the outstanding-write credit limit is not exhausted.
- Retires credits on write responses from both RX channels.

Parameters:
FIFO_DEPTH, 8, ingress FIFO entries; power of 2, minimum 2
MAX_OUTSTANDING, 32, maximum issued-but-unacknowledged writes; minimum 1
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived; not overridden)

Ports:
clk  in  1  CCI interface clock (32ui domain)
rst  in  1  synchronous reset, active-high
usr_wr_valid  in  1  user write request valid
usr_wr_ready  out  1  FIFO can accept a request
usr_wr_hdr  in  61  CCI TX write header, passed through unmodified
usr_wr_data  in  512  cache-line write data
cci_tx_wr_almostfull  in  1  CCI channel 1 almost full
spl_tx_wr_valid  out  1  TX write request valid to CCI, one cycle per request
spl_tx_wr_hdr  out  61  TX write header to CCI
spl_tx_data  out  512  TX write data to CCI
cci_rx_wr_valid0  in  1  write response on RX channel 0
cci_rx_wr_valid1  in  1  write response on RX channel 1
outstanding_cnt  out  CNT_W  writes issued, response not yet received
idle  out  1  FIFO empty, outstanding_cnt==0, spl_tx_wr_valid==0
err_underflow  out  1  sticky: response received while outstanding_cnt==0

Behaviour:
- Reset (rst=1 at a clk edge): FIFO pointers and count cleared, buffered requests discarded. spl_tx_wr_valid=0, spl_tx_wr_hdr=0, spl_tx_data=0, outstanding_cnt=0, err_underflow=0, usr_wr_ready=1 in the cycle after the reset edge, idle=1. Reset mid-transfer drops pending requests with no partial output.
- Ingress handshake: a transfer occurs at an edge where usr_wr_valid & usr_wr_ready. usr_wr_ready = (fifo_count != FIFO_DEPTH), combinational from registered count only; it has no dependency on usr_wr_valid. When full, no accept and no overwrite.
- Issue condition, evaluated each cycle: issue = fifo_non_empty & ~cci_tx_wr_almostfull & (outstanding_cnt < MAX_OUTSTANDING).
- Issue action: on the edge where issue=1, pop the FIFO head into the output registers and set spl_tx_wr_valid=1. Otherwise spl_tx_wr_valid=0 and hdr/data hold their last value.
- spl_tx_wr_valid is registered and never high for two cycles on the same request. There is no backpressure after issue; CCI almost-full slack covers the one-cycle registered-issue latency.
- Latency: a request accepted at edge k is visible as FIFO head after edge k. Earliest spl_tx_wr_valid=1 is in the cycle after edge k+1 (2 cycles).
- Sustained rate: 1 request per cycle when unthrottled.
- Simultaneous push and pop on a full FIFO: pop frees the slot, but usr_wr_ready was 0 that cycle, so no push occurs.
- Simultaneous push and pop on a non-full FIFO: count unchanged.
- Outstanding counter update: next = cnt + issue − cci_rx_wr_valid0 − cci_rx_wr_valid1. Both responses in the same cycle decrement by 2.
- Underflow: if the decrement would take the counter below 0, clamp at 0 and set err_underflow. err_underflow is cleared only by rst. Responses to writes issued before a reset also trigger this flag.
- Counter ceiling: it never exceeds MAX_OUTSTANDING because issue is gated.
- idle is registered-equivalent (derived from registered state only).

Test Plan:
- Reset, then 4 back-to-back requests with hdr=1..4 and almostfull=0 -> spl_tx_wr_valid high in 4 consecutive cycles starting 2 cycles after the first accept, hdr order 1,2,3,4, outstanding_cnt=4; then 4 single-channel responses -> outstanding_cnt=0, idle=1.
- Hold almostfull=1, push 9 requests with FIFO_DEPTH=8 -> usr_wr_ready=0 after the 8th accept, 9th held, no spl valid; release almostfull -> 8 issues, 9th accepted, all 9 issued in order.
- MAX_OUTSTANDING=2, push 5 with no responses -> exactly 2 issues, then stall; one response on channel 0 -> exactly 1 more issue one cycle later; outstanding_cnt stays 2.
- After 3 issues, assert cci_rx_wr_valid0 and cci_rx_wr_valid1 in the same cycle -> outstanding_cnt 3→1; then 2 responses while cnt=1 -> cnt=0, err_underflow=1 and sticky.
- Assert rst mid-stream with 5 requests buffered and cnt=3 -> next cycle: spl_tx_wr_valid=0, outstanding_cnt=0, usr_wr_ready=1, idle=1, err_underflow=0, and no buffered request ever issues.
